// File: rtl/conv_event_window_gen.sv
// conv_event_window_gen: expands one input spike event into the affected output pixels and kernel-weight indices
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      event handshake (ready only while idle)
//   in_x, in_y, in_ch      event column, row and input channel
//   out_valid/out_ready    tuple handshake (held stable while stalled)
//   out_x, out_y           affected output pixel
//   out_kidx, out_ch       weight index ky*K+kx and latched event channel
//   done                   pulses on the cycle the last window position retires
//   err_oob                pulses the cycle after an out-of-image event is dropped
module conv_event_window_gen #(
    parameter int KERNEL_SIZE = 3,
    parameter int IN_CHANNELS = 2,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int COORD_BITS  = 4,
    localparam int CH_BITS    = IN_CHANNELS > 1 ? $clog2(IN_CHANNELS) : 1,
    localparam int KIDX_BITS  = $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COORD_BITS-1:0] in_x,
    input  logic [COORD_BITS-1:0] in_y,
    input  logic [CH_BITS-1:0]    in_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COORD_BITS-1:0] out_x,
    output logic [COORD_BITS-1:0] out_y,
    output logic [KIDX_BITS-1:0]  out_kidx,
    output logic [CH_BITS-1:0]    out_ch,
    output logic                  done,
    output logic                  err_oob
);
    localparam int KB = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
    localparam int SW = COORD_BITS + 2;
    localparam logic signed [SW-1:0] HALF = SW'(KERNEL_SIZE / 2);
    localparam logic signed [SW-1:0] W_S  = SW'(IMG_WIDTH);
    localparam logic signed [SW-1:0] H_S  = SW'(IMG_HEIGHT);
    localparam logic [KB-1:0] K_LAST = KB'(KERNEL_SIZE - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state_q, state_d;
    logic [COORD_BITS-1:0]   x_q, x_d, y_q, y_d;
    logic [CH_BITS-1:0]      ch_q, ch_d;
    logic [KB-1:0]           kx_q, kx_d, ky_q, ky_d;
    logic                    err_q, err_d;
    logic signed [SW-1:0]    ox, oy;
    logic                    in_b, in_img, kx_last, ky_last, adv;

    // Output pixel hit by kernel tap (kx,ky): the tap mirrors around the event.
    assign ox = $signed({2'b00, x_q}) + HALF - $signed({{(SW-KB){1'b0}}, kx_q});
    assign oy = $signed({2'b00, y_q}) + HALF - $signed({{(SW-KB){1'b0}}, ky_q});
    assign in_b = !ox[SW-1] && ox < W_S && !oy[SW-1] && oy < H_S;
    assign in_img = {1'b0, in_x} < (COORD_BITS+1)'(IMG_WIDTH) && {1'b0, in_y} < (COORD_BITS+1)'(IMG_HEIGHT);
    assign kx_last = kx_q == K_LAST;
    assign ky_last = ky_q == K_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ch_d      = ch_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        err_d     = 1'b0;
        adv       = 1'b0;
        done      = 1'b0;
        in_ready  = state_q == IDLE;
        out_valid = 1'b0;
        out_x     = '0;
        out_y     = '0;
        out_kidx  = '0;
        out_ch    = ch_q;
        err_oob   = err_q;
        if (state_q == IDLE) begin
            if (in_valid && in_img) begin
                state_d = SCAN;
                x_d     = in_x;
                y_d     = in_y;
                ch_d    = in_ch;
                kx_d    = '0;
                ky_d    = '0;
            end else if (in_valid) begin
                err_d = 1'b1;
            end
        end else begin
            out_valid = in_b;
            out_x     = in_b ? ox[COORD_BITS-1:0] : '0;
            out_y     = in_b ? oy[COORD_BITS-1:0] : '0;
            out_kidx  = in_b ? KIDX_BITS'(ky_q) * KIDX_BITS'(KERNEL_SIZE) + KIDX_BITS'(kx_q) : '0;
            // Off-image taps burn exactly one cycle; visible taps wait for the consumer.
            adv       = !in_b || out_ready;
            if (adv) begin
                kx_d = kx_last ? '0 : kx_q + 1'b1;
                ky_d = kx_last ? (ky_last ? '0 : ky_q + 1'b1) : ky_q;
                if (kx_last && ky_last) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_event_window_gen.sv
// tb_conv_event_window_gen: self-checking bench for conv_event_window_gen
module tb_conv_event_window_gen;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [3:0] in_x, in_y;
  logic in_ch;
  logic out_valid, out_ready;
  logic [3:0] out_x, out_y, out_kidx;
  logic out_ch;
  logic done, err_oob;
  int n_asrt = 0;
  int n_fail = 0;
  bit [11:0] exp_a [9];
  int n_exp;
  always #5 clk = ~clk;
  conv_event_window_gen dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_kidx(out_kidx), .out_ch(out_ch),
    .done(done), .err_oob(err_oob)
  );
  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_event(input logic [3:0] x, input logic [3:0] y, input logic ch,
                           input bit bp, input int exp_cyc, input int abort_after);
    int idx = 0;
    int cyc = 0;
    bit dn = 0;
    bit held = 0;
    bit [11:0] hold_t = '0;
    chk("in_ready_idle", in_ready, 1'b1);
    in_x = x; in_y = y; in_ch = ch; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!dn && cyc < 60) begin
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      chk("in_ready_scan", in_ready, 1'b0);
      chk("out_ch", out_ch, ch);
      if (held) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_tuple", {out_x, out_y, out_kidx}, hold_t);
      end
      held = out_valid && !out_ready;
      hold_t = {out_x, out_y, out_kidx};
      if (out_valid && out_ready) begin
        chk("tuple", {out_x, out_y, out_kidx}, (idx < n_exp) ? exp_a[idx] : 12'hfff);
        idx++;
      end
      if (done) dn = 1;
      cyc++;
      if (abort_after > 0 && idx == abort_after) return;
      if (!dn) begin @(posedge clk); #1; end
    end
    chk("done_seen", dn, 1'b1);
    chk("n_tuples", idx, n_exp);
    if (exp_cyc > 0) chk("scan_cycles", cyc, exp_cyc);
    @(posedge clk); #1;
    chk("in_ready_after", in_ready, 1'b1);
    chk("valid_after", out_valid, 1'b0);
    chk("done_after", done, 1'b0);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_ch = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_oob, 1'b0);
    chk("rst_tuple", {out_x, out_y, out_kidx, out_ch}, 13'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    exp_a = '{12'h440, 12'h341, 12'h242, 12'h433, 12'h334, 12'h235, 12'h426, 12'h327, 12'h228};
    n_exp = 9;
    run_event(4'd3, 4'd3, 1'b1, 1'b0, 9, 0);
    exp_a = '{12'h110, 12'h011, 12'h103, 12'h004, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    n_exp = 4;
    run_event(4'd0, 4'd0, 1'b0, 1'b0, 9, 0);
    exp_a = '{12'h774, 12'h675, 12'h767, 12'h668, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    n_exp = 4;
    run_event(4'd7, 4'd7, 1'b1, 1'b0, 9, 0);
    exp_a = '{12'h440, 12'h341, 12'h242, 12'h433, 12'h334, 12'h235, 12'h426, 12'h327, 12'h228};
    n_exp = 9;
    run_event(4'd3, 4'd3, 1'b0, 1'b1, 0, 0);
    in_x = 4'd8; in_y = 4'd2; in_ch = 1'b1; in_valid = 1'b1;
    #1;
    chk("oob_in_ready", in_ready, 1'b1);
    chk("oob_err_early", err_oob, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("oob_err_pulse", err_oob, 1'b1);
    chk("oob_no_valid", out_valid, 1'b0);
    chk("oob_ready_kept", in_ready, 1'b1);
    @(posedge clk); #2;
    chk("oob_err_clear", err_oob, 1'b0);
    chk("oob_no_valid2", out_valid, 1'b0);
    exp_a = '{12'h220, 12'h121, 12'h022, 12'h213, 12'h114, 12'h015, 12'h206, 12'h107, 12'h008};
    n_exp = 9;
    run_event(4'd1, 4'd1, 1'b1, 1'b0, 9, 0);
    exp_a = '{12'h440, 12'h341, 12'h242, 12'h433, 12'h334, 12'h235, 12'h426, 12'h327, 12'h228};
    n_exp = 9;
    run_event(4'd3, 4'd3, 1'b1, 1'b0, 0, 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_tuple", {out_x, out_y, out_kidx, out_ch}, 13'd0);
    chk("arst_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("arst_done_hold", done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_a = '{12'h660, 12'h561, 12'h462, 12'h653, 12'h554, 12'h455, 12'h646, 12'h547, 12'h448};
    n_exp = 9;
    run_event(4'd5, 4'd5, 1'b1, 1'b0, 9, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
